// File: rtl/axis_gmii_tx.sv
// AXI4-Stream to GMII/MII frame transmitter: preamble + SFD, payload, zero pad, CRC-32 FCS, IFG.
// In MII mode each byte goes out as two nibbles, low nibble first, on gmii_txd[3:0].
module axis_gmii_tx #(
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned ENABLE_PADDING   = 1,
   parameter int unsigned MIN_FRAME_LENGTH = 64,
   parameter int unsigned USER_WIDTH       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [7:0]            gmii_txd,
   output logic                  gmii_tx_en,
   output logic                  gmii_tx_er,
   input  logic                  clk_enable,
   input  logic                  mii_select,
   input  logic [7:0]            ifg_delay,
   output logic                  start_packet,
   output logic                  error_underflow
);

   if (DATA_WIDTH != 8) begin : g_width_check
      $error("axis_gmii_tx: DATA_WIDTH must be 8");
   end

   localparam int unsigned PadLen = MIN_FRAME_LENGTH - 4;

   typedef enum logic [2:0] {
      StIdle, StPreamble, StPayload, StPad, StFcs, StWaitEnd, StIfg
   } state_e;

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [15:0] frame_cnt_q;
   logic [31:0] crc_q;
   logic [7:0]  data_q;
   logic        last_q;
   logic        user_q;
   logic [7:0]  ifg_len_q;
   logic        mii_odd_q;
   logic [3:0]  hi_q;

   logic        step;
   logic        ready_state;
   logic        accept;
   logic [7:0]  nxt_txd;
   logic        nxt_en;
   logic        nxt_er;
   logic [31:0] crc_inv;
   logic [31:0] crc_nxt;
   logic [15:0] frame_cnt_inc;
   logic        pad_more;
   logic        pad_last;
   logic [7:0]  ifg_eff;
   logic        unused_user;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int k = 0; k < 8; k++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // In MII mode the FSM and the AXI handshake advance only on the high-nibble cycle.
   assign step        = clk_enable && (!mii_select || mii_odd_q);
   assign ready_state = (state_q == StPreamble && cnt_q == 8'd7) ||
                        (state_q == StPayload && !last_q) || (state_q == StWaitEnd);
   assign s_axis_tready = step && ready_state;
   assign accept        = s_axis_tvalid && s_axis_tready;

   assign crc_inv       = ~crc_q;
   assign crc_nxt       = crc_byte(crc_q, (state_q == StPayload) ? data_q : 8'h00);
   assign frame_cnt_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
   assign pad_more      = (ENABLE_PADDING != 0) && (({16'h0, frame_cnt_q} + 32'd1) < PadLen);
   assign pad_last      = ({16'h0, frame_cnt_q} + 32'd1) >= PadLen;
   assign ifg_eff       = (ifg_delay < 8'd12) ? 8'd12 : ifg_delay;
   assign unused_user   = ^s_axis_tuser;

   always_comb begin
      nxt_txd = 8'h00;
      nxt_en  = 1'b0;
      nxt_er  = 1'b0;
      case (state_q)
         StIdle: begin
            if (s_axis_tvalid) begin
               nxt_txd = 8'h55;
               nxt_en  = 1'b1;
            end
         end
         StPreamble: begin
            nxt_txd = (cnt_q == 8'd7) ? 8'hD5 : 8'h55;
            nxt_en  = 1'b1;
            nxt_er  = (cnt_q == 8'd7) && !s_axis_tvalid;
         end
         StPayload: begin
            nxt_txd = data_q;
            nxt_en  = 1'b1;
            nxt_er  = last_q ? user_q : !s_axis_tvalid;
         end
         StPad: nxt_en = 1'b1;
         StFcs: begin
            nxt_en = 1'b1;
            case (cnt_q[1:0])
               2'd0:    nxt_txd = crc_inv[7:0];
               2'd1:    nxt_txd = crc_inv[15:8];
               2'd2:    nxt_txd = crc_inv[23:16];
               default: nxt_txd = crc_inv[31:24];
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         frame_cnt_q <= 16'd0;
         crc_q       <= 32'hFFFFFFFF;
         data_q      <= 8'h00;
         last_q      <= 1'b0;
         user_q      <= 1'b0;
         ifg_len_q   <= 8'd12;
         mii_odd_q   <= 1'b0;
         hi_q        <= 4'h0;
         gmii_txd    <= 8'h00;
         gmii_tx_en  <= 1'b0;
         gmii_tx_er  <= 1'b0;
      end else if (clk_enable) begin
         if (mii_select && !mii_odd_q) begin
            gmii_txd  <= {4'h0, hi_q};
            mii_odd_q <= 1'b1;
         end else begin
            mii_odd_q  <= 1'b0;
            gmii_txd   <= mii_select ? {4'h0, nxt_txd[3:0]} : nxt_txd;
            hi_q       <= nxt_txd[7:4];
            gmii_tx_en <= nxt_en;
            gmii_tx_er <= nxt_er;
            case (state_q)
               StIdle: begin
                  crc_q       <= 32'hFFFFFFFF;
                  frame_cnt_q <= 16'd0;
                  // The first preamble byte goes out on this step so back-to-back gaps equal the IFG.
                  if (s_axis_tvalid) begin
                     state_q      <= StPreamble;
                     cnt_q        <= 8'd1;
                     start_packet <= 1'b1;
                  end
               end
               StPreamble: begin
                  if (cnt_q == 8'd7) begin
                     if (accept) begin
                        data_q  <= s_axis_tdata;
                        last_q  <= s_axis_tlast;
                        user_q  <= s_axis_tuser[0];
                        state_q <= StPayload;
                     end else begin
                        error_underflow <= 1'b1;
                        state_q         <= StWaitEnd;
                     end
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               StPayload: begin
                  crc_q       <= crc_nxt;
                  frame_cnt_q <= frame_cnt_inc;
                  if (last_q) begin
                     cnt_q <= 8'd0;
                     if (user_q) begin
                        state_q   <= StIfg;
                        ifg_len_q <= ifg_eff;
                     end else if (pad_more) begin
                        state_q <= StPad;
                     end else begin
                        state_q <= StFcs;
                     end
                  end else if (accept) begin
                     data_q <= s_axis_tdata;
                     last_q <= s_axis_tlast;
                     user_q <= s_axis_tuser[0];
                  end else begin
                     error_underflow <= 1'b1;
                     state_q         <= StWaitEnd;
                  end
               end
               StPad: begin
                  crc_q       <= crc_nxt;
                  frame_cnt_q <= frame_cnt_inc;
                  if (pad_last) begin
                     state_q <= StFcs;
                     cnt_q   <= 8'd0;
                  end
               end
               StFcs: begin
                  if (cnt_q == 8'd3) begin
                     state_q   <= StIfg;
                     cnt_q     <= 8'd0;
                     ifg_len_q <= ifg_eff;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               StWaitEnd: begin
                  if (accept && s_axis_tlast) begin
                     state_q   <= StIfg;
                     cnt_q     <= 8'd0;
                     ifg_len_q <= ifg_eff;
                  end
               end
               StIfg: begin
                  if (cnt_q == ifg_len_q - 8'd1) begin
                     state_q <= StIdle;
                     cnt_q   <= 8'd0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_gmii_tx.sv
// Directed bench for axis_gmii_tx: table of frames in GMII mode plus hand sequences for
// back-to-back IFG, mid-frame reset and MII nibble mode with a slow clock enable.
module tb_axis_gmii_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic [0:0] s_axis_tuser = 1'b0;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       clk_enable = 1'b1;
   logic       mii_select = 1'b0;
   logic [7:0] ifg_delay = 8'd12;
   logic       start_packet;
   logic       error_underflow;

   axis_gmii_tx #(
      .DATA_WIDTH(8), .ENABLE_PADDING(1), .MIN_FRAME_LENGTH(64), .USER_WIDTH(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
      .clk_enable(clk_enable), .mii_select(mii_select), .ifg_delay(ifg_delay),
      .start_packet(start_packet), .error_underflow(error_underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   bit abort = 0;

   // Clock enable changes 2 time units after the edge, so it is stable at both clock edges.
   bit ce_div = 0;
   int ce_cnt = 0;
   always @(posedge clk) begin
      #2;
      if (ce_div) begin
         ce_cnt = (ce_cnt == 9) ? 0 : ce_cnt + 1;
         clk_enable = (ce_cnt == 0);
      end else begin
         clk_enable = 1'b1;
      end
   end

   // Wire monitor: one sample per enabled edge (a byte in GMII, a nibble in MII).
   logic [7:0] cur[$];
   logic [7:0] got[$];
   bit cur_er, got_er, in_frame, hi_nib_bad;
   int n_done = 0, gap_cnt = 0, last_gap = 0, n_start = 0, n_und = 0;
   always @(posedge clk) begin
      if (rst) begin
         in_frame = 0;
         cur.delete();
      end else if (clk_enable) begin
         #1;
         if (gmii_tx_en) begin
            if (!in_frame) begin
               in_frame = 1;
               cur.delete();
               cur_er = 0;
               last_gap = gap_cnt;
            end
            cur.push_back(mii_select ? {4'h0, gmii_txd[3:0]} : gmii_txd);
            if (mii_select && gmii_txd[7:4] != 4'h0) hi_nib_bad = 1;
            if (gmii_tx_er) cur_er = 1;
         end else if (in_frame) begin
            in_frame = 0;
            got = cur;
            got_er = cur_er;
            n_done++;
            gap_cnt = 1;
         end else begin
            gap_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (start_packet) n_start++;
      if (error_underflow) n_und++;
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ d[k]) r = (r >> 1) ^ 32'hEDB88320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic wait_accept(output bit ok);
      int t;
      t = 0;
      ok = 0;
      while (t < 20000) begin
         @(negedge clk);
         if (s_axis_tready) begin
            @(posedge clk);
            #1;
            ok = 1;
            return;
         end
         t++;
      end
   endtask

   task automatic send_frame(input int len, input logic [7:0] base, input bit user,
                             input int drop_at);
      bit ok;
      for (int i = 0; i < len && !abort; i++) begin
         if (drop_at > 0 && i == drop_at) begin
            s_axis_tvalid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
         end
         s_axis_tdata  = 8'(base + i);
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (i == len - 1);
         s_axis_tuser  = (i == len - 1) ? user : 1'b0;
         wait_accept(ok);
         if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
            abort = 1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_done(input int target, input string nm);
      int t;
      t = 0;
      while (n_done < target && t < 30000) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      if (n_done < target) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s frame_timeout: got %0d frames, required %0d", nm, n_done, target);
         abort = 1;
      end
   endtask

   task automatic check_frame(input string nm, input logic [7:0] b[$], input logic [7:0] pl[$],
                              input int exp_wire, input bit er, input bit exp_fcs);
      int bad;
      logic [31:0] crc;
      check({nm, " wire_len"}, b.size(), exp_wire);
      bad = 0;
      for (int i = 0; i < 8 && i < b.size(); i++)
         if (b[i] != ((i == 7) ? 8'hD5 : 8'h55)) bad++;
      check({nm, " preamble_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < pl.size(); i++)
         if (8 + i >= b.size() || b[8 + i] != pl[i]) bad++;
      check({nm, " payload_bad"}, bad, 0);
      check({nm, " tx_er"}, got_er, er);
      if (exp_fcs) begin
         crc = 32'hFFFFFFFF;
         for (int i = 8; i < b.size(); i++) crc = crc_bits(crc, b[i]);
         check({nm, " fcs_residue"}, crc, 32'hDEBB20E3);
      end
   endtask

   typedef struct {
      int         len;
      logic [7:0] base;
      bit         user;
      int         drop;
      int         ifg;
      int         exp_wire;
      bit         exp_er;
      bit         exp_fcs;
      int         exp_und;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [7:0] pl[$];
      logic [7:0] b[$];
      int nd, n, bad;

      vecs[0] = '{60, 8'h00, 1'b0, 0, 12, 72, 1'b0, 1'b1, 0};
      vecs[1] = '{1, 8'hAB, 1'b0, 0, 12, 72, 1'b0, 1'b1, 0};
      vecs[2] = '{64, 8'h10, 1'b0, 0, 5, 76, 1'b0, 1'b1, 0};
      vecs[3] = '{100, 8'h03, 1'b0, 0, 30, 112, 1'b0, 1'b1, 0};
      vecs[4] = '{20, 8'hC0, 1'b1, 0, 12, 28, 1'b1, 1'b0, 0};
      vecs[5] = '{30, 8'h40, 1'b0, 10, 12, 18, 1'b1, 1'b0, 1};

      // Reset values while rst is held.
      repeat (3) @(posedge clk);
      #1;
      check("rst txd", gmii_txd, 0);
      check("rst tx_en", gmii_tx_en, 0);
      check("rst tx_er", gmii_tx_er, 0);
      check("rst tready", s_axis_tready, 0);
      check("rst start_packet", start_packet, 0);
      check("rst error_underflow", error_underflow, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      for (int v = 0; v < 6 && !abort; v++) begin
         ifg_delay = 8'(vecs[v].ifg);
         n_start = 0;
         n_und = 0;
         nd = n_done;
         send_frame(vecs[v].len, vecs[v].base, vecs[v].user, vecs[v].drop);
         wait_done(nd + 1, $sformatf("vec%0d", v));
         if (abort) break;
         pl.delete();
         n = (vecs[v].drop > 0) ? vecs[v].drop : vecs[v].len;
         for (int i = 0; i < n; i++) pl.push_back(8'(vecs[v].base + i));
         if (!vecs[v].user && vecs[v].drop == 0)
            while (pl.size() < 60) pl.push_back(8'h00);
         check_frame($sformatf("vec%0d", v), got, pl, vecs[v].exp_wire, vecs[v].exp_er,
                     vecs[v].exp_fcs);
         check($sformatf("vec%0d start_pulses", v), n_start, 1);
         check($sformatf("vec%0d underflow_pulses", v), n_und, vecs[v].exp_und);
         repeat (40) @(posedge clk);
         #1;
      end

      // Back-to-back frames: gap is max(ifg_delay, 12) byte times.
      if (!abort) begin
         ifg_delay = 8'd5;
         nd = n_done;
         send_frame(64, 8'h20, 1'b0, 0);
         send_frame(64, 8'h60, 1'b0, 0);
         wait_done(nd + 2, "b2b5");
         check("b2b ifg5 gap", last_gap, 12);
         pl.delete();
         for (int i = 0; i < 64; i++) pl.push_back(8'(8'h60 + i));
         check_frame("b2b5 second", got, pl, 76, 1'b0, 1'b1);
         repeat (40) @(posedge clk);
         #1;
      end
      if (!abort) begin
         ifg_delay = 8'd20;
         nd = n_done;
         send_frame(64, 8'h20, 1'b0, 0);
         send_frame(64, 8'h60, 1'b0, 0);
         wait_done(nd + 2, "b2b20");
         check("b2b ifg20 gap", last_gap, 20);
         repeat (40) @(posedge clk);
         #1;
      end

      // Reset in the middle of a payload: outputs clear, no FCS tail follows.
      if (!abort) begin
         ifg_delay = 8'd12;
         s_axis_tdata = 8'h11;
         s_axis_tvalid = 1'b1;
         s_axis_tlast = 1'b0;
         repeat (20) @(posedge clk);
         #1;
         check("pre_rst tx_en", gmii_tx_en, 1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         check("mid_rst tx_en", gmii_tx_en, 0);
         check("mid_rst txd", gmii_txd, 0);
         check("mid_rst tready", s_axis_tready, 0);
         s_axis_tvalid = 1'b0;
         rst = 1'b0;
         bad = 0;
         repeat (20) begin
            @(posedge clk);
            #1;
            if (gmii_tx_en) bad++;
         end
         check("post_rst tx_en_cycles", bad, 0);
      end

      // MII mode with clock enable 1-in-10.
      if (!abort) begin
         mii_select = 1'b1;
         ce_div = 1;
         repeat (30) @(posedge clk);
         #1;
         hi_nib_bad = 0;
         nd = n_done;
         send_frame(60, 8'h00, 1'b0, 0);
         wait_done(nd + 1, "mii");
         if (!abort) begin
            check("mii nibble_count", got.size(), 144);
            bad = 0;
            for (int i = 0; i < 16 && i < got.size(); i++)
               if (got[i] != ((i == 15) ? 8'h0D : 8'h05)) bad++;
            check("mii preamble_nibbles_bad", bad, 0);
            b.delete();
            for (int i = 0; i + 1 < got.size(); i += 2) b.push_back({got[i + 1][3:0], got[i][3:0]});
            pl.delete();
            for (int i = 0; i < 60; i++) pl.push_back(8'(i));
            check_frame("mii", b, pl, 72, 1'b0, 1'b1);
            check("mii high_nibble_nonzero", hi_nib_bad, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
